// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Each bit lasts exactly CLOCK_FREQ/BAUD_RATE clocks; the serial line is driven from a register.
module uart_tx #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_data_valid,
    output logic       o_ready,
    output logic       o_uart_tx,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_state
);

    localparam int N     = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = (N < 2) ? 1 : $clog2(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (N < 2) begin : g_bad_divisor
        $error("uart_tx: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [2:0]       idx_q,   idx_d;
    logic             stop_q,  stop_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             par_q,   par_d;
    logic             tx_q,    tx_d;
    logic             done_q,  done_d;
    logic             bit_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // The line value for the next bit is loaded on the edge that ends the current one,
    // so tx_q always changes exactly on bit boundaries.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (i_data_valid) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stop_d  = 1'b0;
                    shreg_d = i_data;
                    par_d   = (^i_data) ^ (PARITY == 1);
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (STOP_BITS == 1 || stop_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign o_ready   = (state_q == S_IDLE);
    assign o_busy    = ~o_ready;
    assign o_uart_tx = tx_q;
    assign o_done    = done_q;
    assign o_state   = state_q;

endmodule
